// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU share arbiter: widths, ALU op codes, FSM states.
package alu_arb_pkg;

  localparam int DATA_W = 32;
  localparam int N_REQ  = 2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1101;
  localparam logic [3:0] OP_SRL = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arb_core.sv
// Combinational ALU shared by both requesters; unknown op codes yield 0 and raise illegal.
module alu_arb_core
  import alu_arb_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      // Unsigned compare, result is a single LSB.
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_NOR:  result = ~(a | b);
      OP_SLL:  result = b << shamt;
      OP_SRL:  result = b >> shamt;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ERR_EN to drive rsp_err from the illegal-op flag; otherwise rsp_err is 0.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0][3:0]         req_op,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_b,
  input  logic [N_REQ-1:0][4:0]         req_shamt,
  output logic [N_REQ-1:0]              rsp_valid,
  input  logic [N_REQ-1:0]              rsp_ready,
  output logic [DATA_W-1:0]             rsp_result,
  output logic                          rsp_zero,
  output logic                          rsp_err,
  output logic [1:0]                    dbg_state
);
  import alu_arb_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is only offered in IDLE to the granted requester; rsp_valid is held with
  // stable data until the owner's rsp_ready is seen, and the other rsp_ready bit is ignored.

`ifdef ALU_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;

  logic [1:0]        grant;
  logic [DATA_W-1:0] core_result;
  logic              core_illegal;

  alu_arb_core u_core (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .shamt   (shamt_q),
    .result  (core_result),
    .illegal (core_illegal)
  );

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    shamt_d  = shamt_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_d = grant[1];
          last_d  = grant[1];
          op_d    = req_op[grant[1]];
          a_d     = req_a[grant[1]];
          b_d     = req_b[grant[1]];
          shamt_d = req_shamt[grant[1]];
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = core_result;
        zero_d   = (core_result == '0);
        err_d    = ERR_EN & core_illegal;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shamt_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 Parameter N_REQ, default 2, number of requesters; only 2 is supported.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  2  per-requester request valid; bit i is requester i.
REQ-006 req_ready  output  2  per-requester request accept.
REQ-007 req_op  input  2x4  per-requester ALU control code.
REQ-008 req_a, req_b  input  2x32  per-requester operands; a is rs, b is rt.
REQ-009 req_shamt  input  2x5  per-requester shift amount.
REQ-010 rsp_valid  output  2  per-requester response valid.
REQ-011 rsp_ready  input  2  per-requester response accept.
REQ-012 rsp_result  output  32  shared response result bus.
REQ-013 rsp_zero  output  1  high when rsp_result equals 0.
REQ-014 rsp_err  output  1  illegal-op flag for the current response.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-016 In IDLE, req_ready[i] SHALL be high only for the granted requester i; req_ready SHALL be 0 in EXEC and RESP.
REQ-017 Grant SHALL be round-robin: one valid requester is granted; if both are valid, the requester not in last_grant is granted.
REQ-018 On an accept (req_valid[i] && req_ready[i]), the block SHALL capture op/a/b/shamt, set owner=i and last_grant=i, and go to EXEC.
REQ-019 In EXEC, the block SHALL compute and register the result, then go to RESP unconditionally (one cycle).
REQ-020 Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 SLL (b<<shamt), 1110 SRL (b>>shamt, logical); all other codes are illegal.
REQ-021 ADD/SUB SHALL wrap modulo 2^32 with no overflow flag; SLT SHALL compare unsigned and return 1 or 0.
REQ-022 An illegal op SHALL produce rsp_result=0 and rsp_zero=1.
REQ-023 In RESP, rsp_valid[owner] SHALL be high, the other bit low, and rsp_result/zero/err SHALL be held stable until rsp_ready[owner] is high.
REQ-024 On rsp_valid[owner] && rsp_ready[owner], the block SHALL return to IDLE; a new accept SHALL occur no earlier than the next cycle.
REQ-025 Latency from accept edge to rsp_valid SHALL be 2 cycles; peak throughput SHALL be one op per 3 cycles.
REQ-026 rsp_ready[i] for i != owner SHALL be ignored.
REQ-027 Dropping req_valid before accept SHALL be allowed and SHALL not update last_grant.

Reset
REQ-028 While rst_n is low: state=IDLE, last_grant=1 (requester 0 wins the first tie), owner=0, rsp_valid=0, rsp_result=0, rsp_zero=1, rsp_err=0.
REQ-029 Reset in EXEC or RESP SHALL discard the operation with no response delivered.

Configuration
REQ-030 When macro ALU_ARB_ERR_EN is defined, rsp_err SHALL be 1 for a response from an illegal op and 0 otherwise.
REQ-031 When ALU_ARB_ERR_EN is undefined, rsp_err SHALL be tied 0 and illegal ops SHALL still follow REQ-022.

Structure
REQ-032 Package alu_arb_pkg SHALL hold the op-code constants, the state enum, and DATA_W.
REQ-033 The compute step SHALL be the sub-module alu_arb_core (combinational op decode and result, plus an illegal flag) instantiated once and shared by both requesters.

Verification
REQ-034 Single request: req0 ADD a=0xFFFFFFFF b=1 -> two cycles after accept, rsp_valid=01, result=0, zero=1.
REQ-035 Tie: both valid from reset with req0 AND, req1 OR -> req0 is served first, then req1; with both held valid, grants alternate 0,1,0,1.
REQ-036 Backpressure: rsp_ready[1]=0 for 5 cycles on req1 SLL b=1 shamt=31 -> result=0x80000000 held stable; req_ready=00 throughout.
REQ-037 Illegal op 1111 -> result=0, zero=1, rsp_err=1 with ALU_ARB_ERR_EN, rsp_err=0 without it.
REQ-038 Reset asserted in EXEC -> rsp_valid never rises; the next tie after reset grants req0.
REQ-039 SLT unsigned a=0x80000000 b=1 -> result=0, zero=1; SUB 5-7 -> 0xFFFFFFFE.
